trap_ctrl: RTL and testbench

Machine-mode trap sequencer sitting directly upstream of the CSR register file. It detects pending timer/external interrupts at instruction boundaries and stalls the core. It then writes mepc, mcause and mstatus into the CSR file through its write port and redirects fetch to the trap vector. It also handles `mret`: it restores mstatus and returns to mepc.

---
 rtl/trap_ctrl_pkg.sv | 61 ++++++
 rtl/trap_ctrl_if.sv | 30 +++
 rtl/trap_ctrl_timer.sv | 41 ++++
 rtl/trap_ctrl.sv | 138 +++++++++++++
 tb/tb_trap_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/trap_ctrl_pkg.sv
// trap_pkg: shared types and constants for the machine-mode trap sequencer.
// FSM state encoding, CSR addresses, interrupt cause codes, mstatus/mip bit
// positions and the mstatus rewrite helpers used on trap entry and mret.
package trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE_EPC,
        ST_SAVE_CAUSE,
        ST_SAVE_STATUS,
        ST_RET_STATUS,
        ST_REDIRECT
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;
    localparam logic [31:0] CAUSE_M_EXT   = 32'h8000_000B;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;

    // Trap entry: stash MIE in MPIE, disable interrupts, record M-mode as previous.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // mret: restore MIE from MPIE and set MPIE.
    function automatic logic [31:0] ret_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

    // Build the mip view from the two pending bits.
    function automatic logic [31:0] mip_pack(input logic meip, input logic mtip);
        logic [31:0] r;
        r = '0;
        r[MIP_MEIP] = meip;
        r[MIP_MTIP] = mtip;
        return r;
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: core/CSR-file side signals of the trap sequencer.
// master = core/CSR file side, slave = trap_ctrl.
interface trap_ctrl_if;
    logic        inst_valid;
    logic [31:0] pc;
    logic        is_mret;
    logic        ext_irq;
    logic [31:0] mtimecmp;
    logic [31:0] mstatus;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        stall;
    logic        csr_wr;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mip;

    modport master (
        output inst_valid, pc, is_mret, ext_irq, mtimecmp, mstatus, mie, mtvec, mepc,
        input  stall, csr_wr, csr_addr, csr_wdata, redirect_valid, redirect_pc, mip
    );

    modport slave (
        input  inst_valid, pc, is_mret, ext_irq, mtimecmp, mstatus, mie, mtvec, mepc,
        output stall, csr_wr, csr_addr, csr_wdata, redirect_valid, redirect_pc, mip
    );
endinterface

// File: rtl/trap_ctrl_timer.sv
// trap_timer: mtime counter advancing once every PRESCALE cycles, wrapping at
// 2^32, plus a registered unsigned mtime >= mtimecmp compare (MTIP).
module trap_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_mtimecmp,
    output logic        o_mtip
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] r_pre;
    logic [31:0]   r_mtime;
    logic          r_mtip;
    logic          w_tick;

    assign w_tick = (r_pre == PW'(PRESCALE - 1));

    // Prescaler and free-running mtime; natural 32-bit overflow gives the wrap.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            r_pre   <= '0;
            r_mtime <= '0;
        end else if (w_tick) begin
            r_pre   <= '0;
            r_mtime <= r_mtime + 32'd1;
        end else begin
            r_pre   <= r_pre + 1'b1;
        end
    end

    // MTIP is a registered compare, so it lags mtime by one cycle.
    always_ff @(posedge clk) begin
        if (!rst) r_mtip <= 1'b0;
        else      r_mtip <= (r_mtime >= i_mtimecmp);
    end

    assign o_mtip = r_mtip;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer upstream of the CSR file.
// Takes timer/external interrupts at commit boundaries, writes mepc/mcause/
// mstatus one per cycle, then redirects fetch; also sequences mret.
// Optional: define TRAP_VECTORED_EN to honour vectored mtvec (mode 2'b01).
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic     clk,
    input  logic     rst,
    trap_ctrl_if.slave bus
);
    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_epc;
    logic [31:0] r_cause;
    logic        r_is_trap;

    logic        w_mtip;
    logic        w_ext_en;
    logic        w_tim_en;
    logic        w_int_pend;
    logic        w_take_int;
    logic        w_take_ret;
    logic [31:0] w_cause;
    logic [31:0] w_base;
    logic [31:0] w_trap_target;
    logic        w_unused;

    trap_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_mtimecmp (bus.mtimecmp),
        .o_mtip     (w_mtip)
    );

    assign w_ext_en   = bus.mie[MIP_MEIP] & bus.ext_irq;
    assign w_tim_en   = bus.mie[MIP_MTIP] & w_mtip;
    assign w_int_pend = bus.mstatus[MSTATUS_MIE] & (w_ext_en | w_tim_en);
    assign w_cause    = w_ext_en ? CAUSE_M_EXT : CAUSE_M_TIMER;

    // An interrupt wins over a coincident mret; the mret is then not executed.
    assign w_take_int = rst & (r_state == ST_IDLE) & bus.inst_valid & w_int_pend;
    assign w_take_ret = rst & (r_state == ST_IDLE) & bus.inst_valid & bus.is_mret & ~w_int_pend;

    assign w_base = {bus.mtvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    assign w_trap_target = (bus.mtvec[1:0] == 2'b01) ? (w_base + {r_cause[29:0], 2'b00}) : w_base;
`else
    assign w_trap_target = w_base;
`endif

    assign bus.mip  = mip_pack(bus.ext_irq, w_mtip);
    assign w_unused = ^{bus.mie[31:12], bus.mie[10:8], bus.mie[6:0], bus.mtvec[1:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Capture pc and cause at acceptance so later level changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_epc     <= '0;
            r_cause   <= '0;
            r_is_trap <= 1'b0;
        end else if (w_take_int) begin
            r_epc     <= bus.pc;
            r_cause   <= w_cause;
            r_is_trap <= 1'b1;
        end else if (w_take_ret) begin
            r_is_trap <= 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_take_int)      w_next = ST_SAVE_EPC;
                else if (w_take_ret) w_next = ST_RET_STATUS;
            end
            ST_SAVE_EPC:    w_next = ST_SAVE_CAUSE;
            ST_SAVE_CAUSE:  w_next = ST_SAVE_STATUS;
            ST_SAVE_STATUS: w_next = ST_REDIRECT;
            ST_RET_STATUS:  w_next = ST_REDIRECT;
            ST_REDIRECT:    w_next = ST_IDLE;
            default:        w_next = ST_IDLE;
        endcase
    end

    // Outputs: stall, CSR write port and fetch redirect, decoded from state.
    always_comb begin
        bus.stall          = 1'b0;
        bus.csr_wr         = 1'b0;
        bus.csr_addr       = '0;
        bus.csr_wdata      = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        unique case (r_state)
            ST_IDLE: bus.stall = w_take_int | w_take_ret;
            ST_SAVE_EPC: begin
                bus.stall     = 1'b1;
                bus.csr_wr    = 1'b1;
                bus.csr_addr  = CSR_MEPC;
                bus.csr_wdata = r_epc;
            end
            ST_SAVE_CAUSE: begin
                bus.stall     = 1'b1;
                bus.csr_wr    = 1'b1;
                bus.csr_addr  = CSR_MCAUSE;
                bus.csr_wdata = r_cause;
            end
            ST_SAVE_STATUS: begin
                bus.stall     = 1'b1;
                bus.csr_wr    = 1'b1;
                bus.csr_addr  = CSR_MSTATUS;
                bus.csr_wdata = trap_mstatus(bus.mstatus);
            end
            ST_RET_STATUS: begin
                bus.stall     = 1'b1;
                bus.csr_wr    = 1'b1;
                bus.csr_addr  = CSR_MSTATUS;
                bus.csr_wdata = ret_mstatus(bus.mstatus);
            end
            ST_REDIRECT: begin
                bus.stall          = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = r_is_trap ? w_trap_target : bus.mepc;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed self-checking bench for trap_ctrl.
// Inputs are driven on the falling edge; outputs are checked 1 time unit later.
module tb_trap_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    trap_ctrl_if bus ();

    trap_ctrl #(.PRESCALE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Compare every sequencer output against one expected cycle.
    task automatic expect_out(input string tag, input logic st, input logic wr,
                              input logic [11:0] addr, input logic [31:0] wdata,
                              input logic rv, input logic [31:0] rpc);
        check({tag, ".stall"},     {31'd0, bus.stall},          {31'd0, st});
        check({tag, ".csr_wr"},    {31'd0, bus.csr_wr},         {31'd0, wr});
        check({tag, ".csr_addr"},  {20'd0, bus.csr_addr},       {20'd0, addr});
        check({tag, ".csr_wdata"}, bus.csr_wdata,               wdata);
        check({tag, ".redir_v"},   {31'd0, bus.redirect_valid}, {31'd0, rv});
        check({tag, ".redir_pc"},  bus.redirect_pc,             rpc);
    endtask

    // Full trap sequence starting with acceptance at the next falling edge.
    task automatic run_trap(input string tag, input logic [31:0] pc, input logic mret,
                            input logic [31:0] cause, input logic [31:0] status,
                            input logic [31:0] target);
        @(negedge clk);
        bus.inst_valid = 1'b1;
        bus.pc         = pc;
        bus.is_mret    = mret;
        #1 expect_out({tag, ".T0"}, 1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        bus.inst_valid = 1'b0;
        bus.is_mret    = 1'b0;
        bus.ext_irq    = 1'b0;
        #1 expect_out({tag, ".T1"}, 1'b1, 1'b1, 12'h341, pc, 1'b0, 32'h0);
        @(negedge clk);
        #1 expect_out({tag, ".T2"}, 1'b1, 1'b1, 12'h342, cause, 1'b0, 32'h0);
        @(negedge clk);
        #1 expect_out({tag, ".T3"}, 1'b1, 1'b1, 12'h300, status, 1'b0, 32'h0);
        @(negedge clk);
        #1 expect_out({tag, ".T4"}, 1'b1, 1'b0, 12'h000, 32'h0, 1'b1, target);
        @(negedge clk);
        #1 expect_out({tag, ".T5"}, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_vec;
        logic        seen;

        bus.inst_valid = 1'b0;
        bus.pc         = '0;
        bus.is_mret    = 1'b0;
        bus.ext_irq    = 1'b0;
        bus.mtimecmp   = 32'd1000;
        bus.mstatus    = '0;
        bus.mie        = '0;
        bus.mtvec      = '0;
        bus.mepc       = '0;

        // Reset state: every output at zero.
        repeat (3) @(negedge clk);
        #1 expect_out("reset", 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);
        check("reset.mip", bus.mip, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Globally masked external interrupt: no trap, but mip shows MEIP.
        @(negedge clk);
        bus.mstatus    = 32'h0;
        bus.mie        = 32'h880;
        bus.ext_irq    = 1'b1;
        bus.inst_valid = 1'b1;
        bus.pc         = 32'h50;
        #1 expect_out("masked", 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);
        check("masked.mip", bus.mip, 32'h800);
        @(negedge clk);
        bus.inst_valid = 1'b0;
        bus.ext_irq    = 1'b0;
        #1 expect_out("masked.next", 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);

        // Timer interrupt.
        bus.mstatus  = 32'h8;
        bus.mie      = 32'h80;
        bus.mtvec    = 32'h200;
        bus.mtimecmp = 32'd5;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #1 seen = bus.mip[7];
        end
        check("mtip.seen", bus.mip, 32'h80);
        run_trap("timer", 32'h100, 1'b0, 32'h8000_0007, 32'h1880, 32'h200);

        // External beats timer; ext_irq drops after acceptance.
        bus.mie     = 32'h880;
        bus.ext_irq = 1'b1;
        bus.mtvec   = 32'h201;
`ifdef TRAP_VECTORED_EN
        exp_vec = 32'h22C;
`else
        exp_vec = 32'h200;
`endif
        run_trap("ext", 32'h180, 1'b0, 32'h8000_000B, 32'h1880, exp_vec);

        // mret with no interrupt enabled.
        bus.mie     = 32'h0;
        bus.mstatus = 32'h1880;
        bus.mepc    = 32'h104;
        bus.mtvec   = 32'h400;
        @(negedge clk);
        bus.inst_valid = 1'b1;
        bus.is_mret    = 1'b1;
        bus.pc         = 32'h120;
        #1 expect_out("mret.T0", 1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        bus.inst_valid = 1'b0;
        bus.is_mret    = 1'b0;
        #1 expect_out("mret.T1", 1'b1, 1'b1, 12'h300, 32'h1888, 1'b0, 32'h0);
        @(negedge clk);
        #1 expect_out("mret.T2", 1'b1, 1'b0, 12'h000, 32'h0, 1'b1, 32'h104);
        @(negedge clk);
        #1 expect_out("mret.T3", 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);

        // mret coincident with a pending timer interrupt: the trap wins.
        bus.mstatus = 32'h8;
        bus.mie     = 32'h80;
        run_trap("mret_int", 32'h300, 1'b1, 32'h8000_0007, 32'h1880, 32'h400);

        // Reset asserted in the T+2 cycle of a trap.
        @(negedge clk);
        bus.inst_valid = 1'b1;
        bus.pc         = 32'h500;
        #1 expect_out("rst_mid.T0", 1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        bus.inst_valid = 1'b0;
        #1 expect_out("rst_mid.T1", 1'b1, 1'b1, 12'h341, 32'h500, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 expect_out("rst_mid.T2", 1'b1, 1'b1, 12'h342, 32'h8000_0007, 1'b0, 32'h0);
        @(negedge clk);
        #1 expect_out("rst_mid.T3", 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);
        check("rst_mid.mip", bus.mip, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        #1 expect_out("rst_mid.idle", 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);

        // Timer wrap: preload mtime near the top, MTIP must drop after wrap.
        bus.mie      = 32'h0;
        bus.mstatus  = 32'h0;
        bus.mtimecmp = 32'hFFFF_FFF0;
        @(negedge clk);
        force dut.u_timer.r_mtime = 32'hFFFF_FFF0;
        #1 release dut.u_timer.r_mtime;
        repeat (3) @(negedge clk);
        #1 check("wrap.before", bus.mip, 32'h80);
        repeat (20) @(negedge clk);
        #1 check("wrap.after", bus.mip, 32'h0);
        expect_out("wrap.quiet", 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
